hazard_stall_ctrl: RTL
======================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline control for the 5-stage MIPS core. Drives the IF/ID register enable, the PC
//  enable and the IF/ID and ID/EX flushes. Detects load-use hazards and HI/LO
//  multiply/divide busy hazards, and applies branch/jump redirect flushes.
//  Tracks the multi-cycle mult/div unit with an internal busy timer.
// PARAMETERS
//  REG_W    5   register-specifier width
//  MUL_LAT  5   cycles HI/LO stays busy after a mult issues from EX
//  DIV_LAT  10  cycles HI/LO stays busy after a div issues from EX
//  PERF_W   16  width of the stall-cycle performance counter
// PORTS
//  clk            in   1      rising-edge clock
//  rst_n          in   1      asynchronous, active-low reset
//  id_rs          in   REG_W  rs field of the instruction in ID
//  id_rt          in   REG_W  rt field of the instruction in ID
//  id_use_rs      in   1      ID instruction reads rs
//  id_use_rt      in   1      ID instruction reads rt
//  id_is_md       in   1      ID instr is mult/div/mfhi/mflo/mthi/mtlo
//  ex_rd          in   REG_W  destination register of the instruction in EX
//  ex_reg_we      in   1      EX instruction writes the register file
//  ex_is_load     in   1      EX instruction is a load
//  ex_md_start    in   1      mult/div is issuing in EX this cycle
//  ex_md_div      in   1      qualifies ex_md_start: 1=div, 0=mult
//  br_redirect    in   1      EX resolved a taken branch/jump; PC is being redirected
//  pc_en          out  1      PC register enable
//  if_id_en       out  1      IF/ID register enable
//  if_id_flush    out  1      load a NOP into IF/ID
//  id_ex_flush    out  1      load a bubble into ID/EX
//  md_busy        out  1      HI/LO result pending (registered)
//  perf_stall_cnt out  PERF_W count of stall cycles (registered)
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, md_cnt=0, md_busy=0, perf_stall_cnt=0.
//    With idle inputs: pc_en=1, if_id_en=1, flushes=0.
//  - load_use = ex_is_load & ex_reg_we & (ex_rd!=0) &
//               ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
//  - md_stall = id_is_md & (md_busy | ex_md_start).
//  - stall    = load_use | md_stall.
//  - Outputs are combinational from the inputs and registered state, with zero latency:
//    br_redirect=1 -> pc_en=1, if_id_en=1, if_id_flush=1, id_ex_flush=1
//                     (the redirect overrides the stall; the ID instruction is wrong-path).
//    else stall=1  -> pc_en=0, if_id_en=0, if_id_flush=0, id_ex_flush=1.
//    else          -> pc_en=1, if_id_en=1, flushes=0.
//  - FSM (md timer), states IDLE and BUSY:
//    IDLE: ex_md_start -> BUSY, md_cnt <= ex_md_div ? DIV_LAT : MUL_LAT.
//    BUSY: md_cnt decrements by 1 per cycle; md_cnt==1 and no start -> IDLE, md_cnt=0.
//    ex_md_start while in BUSY: md_cnt reloads from the new op, state stays BUSY.
//    ex_md_start takes effect even when br_redirect=1 (the EX instruction is older and
//    correct-path).
//  - md_busy = (state==BUSY). md_cnt width is $clog2(max(MUL_LAT,DIV_LAT)+1).
//  - perf_stall_cnt increments on every cycle with stall & ~br_redirect.
//    It saturates at all-ones and never wraps.
//  - rst_n asserted mid-operation aborts BUSY immediately, with no residual stall.
// STRUCTURE
//  - Shared package pipe_ctrl_pkg holds: the md state enum (IDLE, BUSY), the
//    MUL_LAT/DIV_LAT defaults, and REG_W.
//  - One sub-module, md_busy_timer: FSM plus down-counter.
//    Inputs: start and is_div. Outputs: busy.
//    Hazard decode and the perf counter stay in the top module.
// TESTING
//  - Reset/idle: rst_n=0 then 1, all inputs 0 -> pc_en=1, if_id_en=1, flushes=0,
//    md_busy=0, perf=0.
//  - Load-use: ex_is_load=1, ex_reg_we=1, ex_rd=8, id_rs=8, id_use_rs=1 ->
//    pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle.
//    Same stimulus with ex_rd=0 -> no stall.
//  - Mult busy: ex_md_start=1, ex_md_div=0 at cycle T, then id_is_md=1 from T ->
//    stall at T..T+5, released at T+6. md_busy is 1 for exactly 5 cycles.
//  - Div restart: div at T, mult at T+3 -> md_busy is 1 through T+8 and 0 at T+9.
//  - Redirect priority: load_use=1 and br_redirect=1 in the same cycle -> pc_en=1,
//    if_id_en=1, if_id_flush=1, id_ex_flush=1. perf_stall_cnt does not increment.
//  - Perf saturation/reset: PERF_W=4, hold stall for 20 cycles -> count stays at 15.
//    Drop rst_n during BUSY -> md_busy=0 and the count is 0 immediately.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and defaults for the pipeline stall controller
package pipe_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam int REG_W       = 5;
    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/md_busy_timer.sv
// rtl/md_busy_timer.sv - mult/div HI/LO busy timer: two-state FSM plus down-counter
module md_busy_timer
    import pipe_ctrl_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int CW = $clog2(max_int(MUL_LAT, DIV_LAT) + 1);

    md_state_t       state, state_nxt;
    logic [CW-1:0]   md_cnt, md_cnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            md_cnt <= '0;
        end else begin
            state  <= state_nxt;
            md_cnt <= md_cnt_nxt;
        end
    end

    // A new start always reloads, even mid-operation, so back-to-back ops restart the timer.
    always_comb begin
        state_nxt  = state;
        md_cnt_nxt = md_cnt;
        if (start) begin
            state_nxt  = BUSY;
            md_cnt_nxt = is_div ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else begin
            case (state)
                IDLE: begin
                    md_cnt_nxt = '0;
                end
                BUSY: begin
                    if (md_cnt <= CW'(1)) begin
                        state_nxt  = IDLE;
                        md_cnt_nxt = '0;
                    end else begin
                        md_cnt_nxt = md_cnt - CW'(1);
                    end
                end
                default: begin
                    state_nxt  = IDLE;
                    md_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy = (state == BUSY);
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// rtl/hazard_stall_ctrl.sv - load-use / HI-LO hazard stall and branch-redirect flush control
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W   = pipe_ctrl_pkg::REG_W,
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF,
    parameter int PERF_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_is_md,
    input  logic [REG_W-1:0]  ex_rd,
    input  logic              ex_reg_we,
    input  logic              ex_is_load,
    input  logic              ex_md_start,
    input  logic              ex_md_div,
    input  logic              br_redirect,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              md_busy,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    logic load_use;
    logic md_stall;
    logic stall;

    md_busy_timer #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (ex_md_start),
        .is_div (ex_md_div),
        .busy   (md_busy)
    );

    always_comb begin
        load_use = ex_is_load && ex_reg_we && (ex_rd != '0) &&
                   ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
        // An op issuing in EX this cycle is not yet visible in md_busy, so check it directly.
        md_stall = id_is_md && (md_busy || ex_md_start);
        stall    = load_use || md_stall;
    end

    // The redirect wins: the ID instruction is wrong-path, so flushing it beats stalling it.
    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (br_redirect) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (stall) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt <= '0;
        end else if (stall && !br_redirect && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + PERF_W'(1);
        end
    end

endmodule
